// File: rtl/mmio_stats_responder.sv
// Host MMIO responder: 64-bit statistics counters, cycle counter and sticky ERROR_REG,
// served through a fixed two-cycle request/acknowledge pipeline with odd parity.
module mmio_stats_responder #(
   parameter int NUM_STATS = 14
) (
   input  logic                 clock,
   input  logic                 rstn,
   input  logic                 ha_mmval,
   input  logic                 ha_mmcfg,
   input  logic                 ha_mmrnw,
   input  logic                 ha_mmdw,
   input  logic [23:0]          ha_mmad,
   input  logic [63:0]          ha_mmdata,
   input  logic                 ha_mmdatapar,
   output logic                 ah_mmack,
   output logic [63:0]          ah_mmdata,
   output logic                 ah_mmdatapar,
   input  logic [NUM_STATS-1:0] stat_inc_in,
   input  logic                 clear_stats,
   input  logic                 job_running,
   input  logic [63:0]          error_in,
   output logic [63:0]          error_reg_out,
   output logic                 mmio_parity_err
);

   // Quad-word indices (word address bits [21:1]); the top two address bits alias.
   localparam logic [20:0] ERR_REG_A = 21'h1FFFF7;
   localparam logic [20:0] ERR_ACK_A = 21'h1FFFF6;
   localparam logic [20:0] STAT0_A   = 21'h1FFFF5;
   localparam logic [20:0] CYCLE_A   = 21'h1FFFE7;

   // Request stage (cycle N+1)
   logic        req_q;
   logic        rnw_q;
   logic        dw_q;
   logic [21:0] ad_q;
   logic [63:0] wdata_q;
   logic        wpar_q;

   // Response stage (cycle N+2)
   logic        ack_q;
   logic [63:0] rdata_q;
   logic [63:0] rdata_d;
   logic        rpar_q;

   logic [63:0] cnt_q [NUM_STATS];
   logic [63:0] cyc_q;
   logic [63:0] err_q;
   logic [63:0] err_d;
   logic [63:0] err_clr;
   logic        perr_q;
   logic        perr_d;

   logic        accept;
   logic [20:0] dec_a;
   logic        sel_hit;
   logic [63:0] sel_val;
   logic        wpar_ok;

   // A new request is taken only when nothing is in flight.
   assign accept = ha_mmval & ~ha_mmcfg & ~req_q & ~ack_q;

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         req_q   <= 1'b0;
         rnw_q   <= 1'b0;
         dw_q    <= 1'b0;
         ad_q    <= '0;
         wdata_q <= '0;
         wpar_q  <= 1'b0;
      end else begin
         req_q <= accept;
         if (accept) begin
            rnw_q   <= ha_mmrnw;
            dw_q    <= ha_mmdw;
            ad_q    <= ha_mmad[21:0];
            wdata_q <= ha_mmdata;
            wpar_q  <= ha_mmdatapar;
         end
      end
   end

   // Dropping address bit 0 gives the even-forced decode for 64-bit accesses.
   assign dec_a   = ad_q[21:1];
   assign wpar_ok = ^{wdata_q, wpar_q};

   always_comb begin
      sel_hit = 1'b0;
      sel_val = '0;
      if (dec_a == ERR_REG_A) begin
         sel_hit = 1'b1;
         sel_val = err_q;
      end else if (dec_a == CYCLE_A) begin
         sel_hit = 1'b1;
         sel_val = cyc_q;
      end
      for (int i = 0; i < NUM_STATS; i++) begin
         if (dec_a == STAT0_A - 21'(i)) begin
            sel_hit = 1'b1;
            sel_val = cnt_q[i];
         end
      end
   end

   always_comb begin
      rdata_d = '0;
      if (req_q && rnw_q && sel_hit) begin
         if (dw_q)
            rdata_d = sel_val;
         else if (ad_q[0])
            rdata_d = {2{sel_val[31:0]}};
         else
            rdata_d = {2{sel_val[63:32]}};
      end
   end

   always_comb begin
      err_clr = '0;
      if (req_q && !rnw_q && dw_q && wpar_ok && dec_a == ERR_ACK_A)
         err_clr = wdata_q;
      err_d  = (err_q & ~err_clr) | error_in;
      perr_d = perr_q | (req_q & ~rnw_q & ~wpar_ok);
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
         rpar_q  <= 1'b1;
         err_q   <= '0;
         perr_q  <= 1'b0;
      end else begin
         ack_q   <= req_q;
         rdata_q <= rdata_d;
         rpar_q  <= ~^rdata_d;
         err_q   <= err_d;
         perr_q  <= perr_d;
      end
   end

   // Clear has priority over increment; counters wrap naturally.
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         cyc_q <= '0;
         for (int i = 0; i < NUM_STATS; i++) cnt_q[i] <= '0;
      end else begin
         if (clear_stats)      cyc_q <= '0;
         else if (job_running) cyc_q <= cyc_q + 64'd1;
         for (int i = 0; i < NUM_STATS; i++) begin
            if (clear_stats)         cnt_q[i] <= '0;
            else if (stat_inc_in[i]) cnt_q[i] <= cnt_q[i] + 64'd1;
         end
      end
   end

   assign ah_mmack        = ack_q;
   assign ah_mmdata       = rdata_q;
   assign ah_mmdatapar    = rpar_q;
   assign error_reg_out   = err_q;
   assign mmio_parity_err = perr_q;

endmodule

// File: tb/tb_mmio_stats_responder.sv
// Self-checking bench for mmio_stats_responder: vector table, directed corner
// sequences and randomized traffic against a behavioural register-map model.
module tb_mmio_stats_responder;

   logic        clock = 1'b0;
   logic        rstn;
   logic        ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw, ha_mmdatapar;
   logic [23:0] ha_mmad;
   logic [63:0] ha_mmdata;
   logic        ah_mmack, ah_mmdatapar;
   logic [63:0] ah_mmdata;
   logic [13:0] stat_inc_in;
   logic        clear_stats, job_running;
   logic [63:0] error_in, error_reg_out;
   logic        mmio_parity_err;

   mmio_stats_responder #(.NUM_STATS(14)) dut (
      .clock(clock), .rstn(rstn),
      .ha_mmval(ha_mmval), .ha_mmcfg(ha_mmcfg), .ha_mmrnw(ha_mmrnw), .ha_mmdw(ha_mmdw),
      .ha_mmad(ha_mmad), .ha_mmdata(ha_mmdata), .ha_mmdatapar(ha_mmdatapar),
      .ah_mmack(ah_mmack), .ah_mmdata(ah_mmdata), .ah_mmdatapar(ah_mmdatapar),
      .stat_inc_in(stat_inc_in), .clear_stats(clear_stats), .job_running(job_running),
      .error_in(error_in), .error_reg_out(error_reg_out), .mmio_parity_err(mmio_parity_err)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Behavioural model of the register file
   logic [63:0] cnt_m [14];
   logic [63:0] cyc_m, err_m, clr_m;
   bit          perr_m, perr_pend;
   bit          rand_mode = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 14; i++) cnt_m[i] = '0;
      cyc_m = '0; err_m = '0; clr_m = '0; perr_m = 0; perr_pend = 0;
   endtask

   // Register contents visible to a read at this word address.
   function automatic logic [63:0] model_read(input logic [23:0] ad, input logic dw);
      logic [21:0] base;
      logic [63:0] v;
      bit          hit;
      base = {ad[21:1], 1'b0};
      hit = 1; v = '0;
      if (base == 22'h3FFFEE)      v = err_m;
      else if (base == 22'h3FFFCE) v = cyc_m;
      else begin
         hit = 0;
         for (int i = 0; i < 14; i++)
            if (base == 22'h3FFFEA - 22'(2 * i)) begin hit = 1; v = cnt_m[i]; end
      end
      if (!hit) return '0;
      if (dw) return v;
      return ad[0] ? {2{v[31:0]}} : {2{v[63:32]}};
   endfunction

   task automatic tick();
      if (rand_mode) begin
         stat_inc_in = 14'($urandom);
         clear_stats = ($urandom_range(0, 40) == 0);
         job_running = 1'($urandom_range(0, 1));
         error_in    = ($urandom_range(0, 5) == 0) ? (64'd1 << $urandom_range(0, 63)) : 64'd0;
      end
      for (int i = 0; i < 14; i++)
         if (clear_stats) cnt_m[i] = '0;
         else if (stat_inc_in[i]) cnt_m[i] = cnt_m[i] + 64'd1;
      if (clear_stats) cyc_m = '0;
      else if (job_running) cyc_m = cyc_m + 64'd1;
      err_m  = (err_m & ~clr_m) | error_in;
      clr_m  = '0;
      perr_m = perr_m | perr_pend;
      perr_pend = 0;
      @(posedge clock); #1;
   endtask

   // One complete access: request in N, response sampled in N+2, idle checked in N+3.
   task automatic mmio(input bit rnw, input bit dw, input logic [23:0] ad, input logic [63:0] wd,
                       input bit bad_par, output bit acked, output logic [63:0] rd,
                       output logic rp, output logic [63:0] exp_rd, output bit ack_after);
      ha_mmval = 1; ha_mmcfg = 0; ha_mmrnw = rnw; ha_mmdw = dw; ha_mmad = ad;
      ha_mmdata = wd; ha_mmdatapar = (~^wd) ^ bad_par;
      tick();
      ha_mmval = 0;
      exp_rd = rnw ? model_read(ad, dw) : 64'd0;
      if (!rnw) begin
         if (bad_par) perr_pend = 1;
         else if (dw && ad[21:1] == 21'h1FFFF6) clr_m = wd;
      end
      tick();
      acked = ah_mmack; rd = ah_mmdata; rp = ah_mmdatapar;
      tick();
      ack_after = ah_mmack;
   endtask

   typedef struct {
      logic        dw;
      logic [23:0] ad;
      logic [63:0] exp_d;
      logic        exp_p;
   } vec_t;

   vec_t vecs [10];

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ack"},  64'(ah_mmack), 64'd0);
      check({tag, "_data"}, ah_mmdata, 64'd0);
      check({tag, "_par"},  64'(ah_mmdatapar), 64'd1);
      check({tag, "_err"},  error_reg_out, 64'd0);
      check({tag, "_perr"}, 64'(mmio_parity_err), 64'd0);
   endtask

   initial begin
      bit          ak, ak2, any_ack;
      logic [63:0] rd, ex;
      logic        rp;

      vecs[0] = '{1'b1, 24'h3FFFE6, 64'h5, 1'b1};
      vecs[1] = '{1'b0, 24'h3FFFDE, 64'h0, 1'b1};
      vecs[2] = '{1'b0, 24'h3FFFDF, {2{32'h3}}, 1'b1};
      vecs[3] = '{1'b1, 24'h3FFFDF, 64'h3, 1'b1};
      vecs[4] = '{1'b1, 24'hFFFFE6, 64'h5, 1'b1};
      vecs[5] = '{1'b1, 24'h000010, 64'h0, 1'b1};
      vecs[6] = '{1'b1, 24'h3FFFEA, 64'h0, 1'b1};
      vecs[7] = '{1'b0, 24'h3FFFE7, {2{32'h5}}, 1'b1};
      vecs[8] = '{1'b1, 24'h3FFFD0, 64'h1, 1'b0};
      vecs[9] = '{1'b0, 24'h3FFFD1, {2{32'h1}}, 1'b1};

      // clock/reset
      rstn = 0; ha_mmval = 0; ha_mmcfg = 0; ha_mmrnw = 0; ha_mmdw = 0; ha_mmad = '0;
      ha_mmdata = '0; ha_mmdatapar = 0; stat_inc_in = '0; clear_stats = 0;
      job_running = 0; error_in = '0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_reset_outputs("reset");
      rstn = 1;
      tick();

      // Preload: DONE_READ x5, PAGED x3, NLOCK x1
      stat_inc_in = 14'b00_0000_0000_0100; repeat (5) tick();
      stat_inc_in = 14'b00_0000_0100_0000; repeat (3) tick();
      stat_inc_in = 14'b10_0000_0000_0000; tick();
      stat_inc_in = '0;

      for (int i = 0; i < 10; i++) begin
         mmio(1, vecs[i].dw, vecs[i].ad, 64'd0, 0, ak, rd, rp, ex, ak2);
         check($sformatf("vec%0d_ack", i), 64'(ak), 64'd1);
         check($sformatf("vec%0d_data", i), rd, vecs[i].exp_d);
         check($sformatf("vec%0d_par", i), 64'(rp), 64'(vecs[i].exp_p));
         check($sformatf("vec%0d_ackpulse", i), 64'(ak2), 64'd0);
      end

      // ERROR_REG set, write-1-to-clear, bad-parity write
      error_in = 64'h11; tick(); error_in = '0;
      check("err_set", error_reg_out, 64'h11);
      mmio(0, 1, 24'hFFFFEC, 64'h1, 0, ak, rd, rp, ex, ak2);
      check("err_wr_ack", 64'(ak), 64'd1);
      check("err_wr_data", rd, 64'd0);
      check("err_cleared", error_reg_out, 64'h10);
      check("perr_clean", 64'(mmio_parity_err), 64'd0);
      mmio(0, 1, 24'hFFFFEC, 64'h10, 1, ak, rd, rp, ex, ak2);
      check("badpar_ack", 64'(ak), 64'd1);
      check("badpar_keep", error_reg_out, 64'h10);
      check("badpar_perr", 64'(mmio_parity_err), 64'd1);
      mmio(0, 0, 24'hFFFFEC, 64'h10, 0, ak, rd, rp, ex, ak2);
      check("dw0_wr_noeffect", error_reg_out, 64'h10);
      mmio(1, 1, 24'h3FFFEE, 64'd0, 0, ak, rd, rp, ex, ak2);
      check("err_read", rd, 64'h10);

      // Cycle counter
      job_running = 1; repeat (100) tick(); job_running = 0;
      mmio(1, 1, 24'hFFFFCE, 64'd0, 0, ak, rd, rp, ex, ak2);
      check("cycle_100", rd, 64'd100);

      // Clear beats increment
      stat_inc_in = 14'b1; repeat (2) tick();
      clear_stats = 1; tick();
      clear_stats = 0; stat_inc_in = '0;
      mmio(1, 1, 24'h3FFFEA, 64'd0, 0, ak, rd, rp, ex, ak2);
      check("clear_cnt0", rd, 64'd0);
      mmio(1, 1, 24'h3FFFE6, 64'd0, 0, ak, rd, rp, ex, ak2);
      check("clear_cnt2", rd, 64'd0);

      // Busy window: second request one cycle later is dropped
      ha_mmval = 1; ha_mmrnw = 1; ha_mmdw = 1; ha_mmad = 24'h000010; tick();
      tick();
      ha_mmval = 0;
      any_ack = ah_mmack;
      check("busy_first_ack", 64'(any_ack), 64'd1);
      check("busy_first_par", 64'(ah_mmdatapar), 64'd1);
      any_ack = 0;
      repeat (4) begin tick(); any_ack |= ah_mmack; end
      check("busy_dropped", 64'(any_ack), 64'd0);

      // Config-space request is ignored
      ha_mmval = 1; ha_mmcfg = 1; tick(); ha_mmval = 0; ha_mmcfg = 0;
      any_ack = 0;
      repeat (4) begin tick(); any_ack |= ah_mmack; end
      check("cfg_noack", 64'(any_ack), 64'd0);

      // Reset at N+1 of a read
      ha_mmval = 1; ha_mmrnw = 1; ha_mmdw = 1; ha_mmad = 24'h3FFFEE; tick();
      ha_mmval = 0;
      rstn = 0; #1;
      model_reset();
      check_reset_outputs("midreset");
      @(posedge clock); #1;
      rstn = 1;
      any_ack = 0;
      repeat (4) begin tick(); any_ack |= ah_mmack; end
      check("midreset_noack", 64'(any_ack), 64'd0);

      // Randomized traffic against the model
      rand_mode = 1;
      for (int n = 0; n < 300; n++) begin
         bit          rnw, dw, bp;
         logic [23:0] ad;
         logic [63:0] wd;
         rnw = ($urandom_range(0, 3) != 0);
         dw  = 1'($urandom_range(0, 1));
         bp  = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 4))
            0:       ad = 24'h3FFFEC | 24'($urandom_range(0, 3) << 22);
            1:       ad = 24'h3FFFEE + 24'($urandom_range(0, 1));
            2:       ad = 24'h3FFFCE + 24'($urandom_range(0, 1));
            3:       ad = 24'($urandom);
            default: ad = 24'h3FFFD0 + 24'($urandom_range(0, 27));
         endcase
         wd = {$urandom, $urandom};
         mmio(rnw, dw, ad, wd, bp, ak, rd, rp, ex, ak2);
         check($sformatf("rnd%0d_ack", n), 64'(ak), 64'd1);
         check($sformatf("rnd%0d_data", n), rd, ex);
         check($sformatf("rnd%0d_par", n), 64'(rp), 64'(~^ex));
         check($sformatf("rnd%0d_err", n), error_reg_out, err_m);
         check($sformatf("rnd%0d_perr", n), 64'(mmio_parity_err), 64'(perr_m));
      end
      rand_mode = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
